traffic_light_fsm: RTL and testbench
====================================

Name: traffic_light_fsm

Overview:
- Downstream consumer of the synchronizer stage: takes the already-synchronized traffic_sensor, walk_request and reprogram levels, plus a 1 Hz enable tick.
- Sequences main-street, side-street and walk lights through a timed Moore state machine.
- Holds three programmable interval registers (base, extended, yellow).
- Exposes the remaining-time count for the display stage.

Parameters:
- TW, 4, width of interval values and of the countdown counter
- T_BASE_DEFAULT, 6, base green interval in ticks
- T_EXT_DEFAULT, 3, extended green / walk interval in ticks
- T_YEL_DEFAULT, 2, yellow interval in ticks

Ports:
- clk  in  1  system clock
- global_reset  in  1  asynchronous, active-high reset
- one_hz_enable  in  1  single-cycle tick, one per second
- traffic_sensor_sync  in  1  side-street car present (level)
- walk_request_sync  in  1  pedestrian button (level)
- reprogram_sync  in  1  write interval register (level)
- time_parameter_selector  in  2  00 base, 01 extended, 10 yellow, 11 restore all defaults
- time_value  in  TW  value to program
- main_light  out  3  {red,yellow,green}, one-hot
- side_light  out  3  {red,yellow,green}, one-hot
- walk_light  out  1  walk lamp
- time_remaining  out  TW  current countdown value

Behaviour:
- Reset: global_reset is asynchronous and active-high; when asserted it overrides everything and sets:
  - state = MG
  - counter = T_BASE_DEFAULT
  - intervals = defaults
  - walk_pending = 0
  - main_light = 001, side_light = 100, walk_light = 0, time_remaining = 6
- States and outputs (main/side/walk):
  - MG 001/100/0
  - MG_EXT 001/100/0
  - MY 010/100/0
  - WALK 100/100/1
  - SG 100/001/0
  - SG_EXT 100/001/0
  - SY 100/010/0
- All outputs are decoded from the state and counter registers only; there is no combinational input-to-output path.
- Timer:
  - On entry to a state, the counter loads that state's interval.
  - Each one_hz_enable decrements it.
  - A tick arriving with counter == 1 causes the transition at that same edge, with the counter reloaded for the new state. Each state therefore lasts exactly N ticks. The counter never reaches 0.
- Intervals: MG = base, MG_EXT = ext, MY = yel, WALK = ext, SG = base, SG_EXT = ext, SY = yel.
- Transitions at expiry:
  - MG -> MG_EXT if traffic_sensor_sync = 1, else MY
  - MG_EXT -> MY
  - MY -> WALK if walk_pending, else SG
  - WALK -> SG
  - SG -> SG_EXT if traffic_sensor_sync = 1, else SY
  - SG_EXT -> SY
  - SY -> MG
- The sensor is sampled only on the expiry edge.
- walk_pending:
  - Set on any cycle where walk_request_sync = 1 and state != WALK.
  - Cleared on the edge entering WALK; clear wins over a simultaneous set.
  - Requests made while in WALK are ignored.
- Reprogram (priority over tick and over state transitions):
  - While reprogram_sync = 1, each edge writes time_value into the selected register.
  - A time_value of 0 writes that register's default.
  - Selector 11 restores all three defaults and ignores time_value.
  - State is forced to MG and the counter loads the effective new base value each cycle.
  - walk_pending is retained.
  - Normal sequencing resumes on the first edge with reprogram_sync = 0.
- A tick coincident with reprogram is discarded.
- Reset mid-state returns immediately to the reset values above; programmed intervals are lost.

Decomposition:
- Shared package traffic_pkg holds:
  - state encoding constants
  - selector codes (SEL_BASE, SEL_EXT, SEL_YEL, SEL_DEFAULTS)
  - light codes (LIGHT_RED = 100, LIGHT_YEL = 010, LIGHT_GRN = 001)
- One sub-module, timing_parameters: the three interval registers with their reprogram and default logic. It outputs the interval for a given state select. The FSM and countdown stay in the top module.

Test Plan:
- Reset, ticks every 4 clk, all inputs low -> MG 6 ticks, MY 2, SG 6, SY 2, back to MG at tick 16; time_remaining counts 6..1 in MG.
- traffic_sensor_sync held high -> MG 6 + MG_EXT 3 + MY 2 + SG 6 + SG_EXT 3 + SY 2 = 22-tick cycle.
- walk_request_sync pulsed 1 clk during MG -> after MY, WALK for 3 ticks with walk_light = 1 and both streets red, then SG. A second pulse during WALK produces no extra WALK in the next cycle.
- reprogram_sync = 1 with selector 00 and time_value 9, during SG -> state MG, time_remaining = 9, MG lasts 9 ticks. Then selector 11 -> base back to 6.
- Program yellow with time_value 0 -> yellow stays 2. A tick on the same edge as reprogram -> the counter is not decremented.
- Assert global_reset asynchronously mid-SY between clk edges -> outputs go to 001/100/0 and time_remaining = 6 before the next edge; walk_pending is cleared.

Source files
------------

// File: rtl/traffic_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | traffic_pkg : shared state, selector and lamp encodings for the          |
// | traffic-light controller.                          Revision 1.0          |
// +--------------------------------------------------------------------------+
package traffic_pkg;

  typedef enum logic [2:0] {
    ST_MG     = 3'd0,
    ST_MG_EXT = 3'd1,
    ST_MY     = 3'd2,
    ST_WALK   = 3'd3,
    ST_SG     = 3'd4,
    ST_SG_EXT = 3'd5,
    ST_SY     = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    IV_BASE = 2'd0,
    IV_EXT  = 2'd1,
    IV_YEL  = 2'd2
  } interval_e;

  localparam logic [1:0] SEL_BASE     = 2'b00;
  localparam logic [1:0] SEL_EXT      = 2'b01;
  localparam logic [1:0] SEL_YEL      = 2'b10;
  localparam logic [1:0] SEL_DEFAULTS = 2'b11;

  localparam logic [2:0] LIGHT_RED = 3'b100;
  localparam logic [2:0] LIGHT_YEL = 3'b010;
  localparam logic [2:0] LIGHT_GRN = 3'b001;

  function automatic interval_e interval_of(input state_e st);
    case (st)
      ST_MG, ST_SG:                       interval_of = IV_BASE;
      ST_MG_EXT, ST_SG_EXT, ST_WALK:      interval_of = IV_EXT;
      ST_MY, ST_SY:                       interval_of = IV_YEL;
      default:                            interval_of = IV_BASE;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/traffic_light_fsm_timing_parameters.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | timing_parameters : base / extended / yellow interval registers with     |
// | reprogram and default-restore logic.               Revision 1.0          |
// +--------------------------------------------------------------------------+
module timing_parameters
  import traffic_pkg::*;
#(
  parameter int TW             = 4,
  parameter int T_BASE_DEFAULT = 6,
  parameter int T_EXT_DEFAULT  = 3,
  parameter int T_YEL_DEFAULT  = 2
) (
  input  logic          clk,
  input  logic          global_reset,
  input  logic          reprogram,
  input  logic [1:0]    sel,
  input  logic [TW-1:0] value,
  input  interval_e     interval_sel,
  output logic [TW-1:0] interval,
  output logic [TW-1:0] base_next
);

  localparam logic [TW-1:0] C_BASE_DEF = TW'(T_BASE_DEFAULT);
  localparam logic [TW-1:0] C_EXT_DEF  = TW'(T_EXT_DEFAULT);
  localparam logic [TW-1:0] C_YEL_DEF  = TW'(T_YEL_DEFAULT);

  logic [TW-1:0] base_q, base_d;
  logic [TW-1:0] ext_q, ext_d;
  logic [TW-1:0] yel_q, yel_d;

  always_comb begin
    base_d = base_q;
    ext_d  = ext_q;
    yel_d  = yel_q;
    if (reprogram) begin
      // A zero interval would stall the countdown, so zero means "default"
      case (sel)
        SEL_BASE: base_d = (value == '0) ? C_BASE_DEF : value;
        SEL_EXT:  ext_d  = (value == '0) ? C_EXT_DEF  : value;
        SEL_YEL:  yel_d  = (value == '0) ? C_YEL_DEF  : value;
        default: begin
          base_d = C_BASE_DEF;
          ext_d  = C_EXT_DEF;
          yel_d  = C_YEL_DEF;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge global_reset) begin
    if (global_reset) begin
      base_q <= C_BASE_DEF;
      ext_q  <= C_EXT_DEF;
      yel_q  <= C_YEL_DEF;
    end else begin
      base_q <= base_d;
      ext_q  <= ext_d;
      yel_q  <= yel_d;
    end
  end

  always_comb begin
    case (interval_sel)
      IV_EXT:  interval = ext_q;
      IV_YEL:  interval = yel_q;
      default: interval = base_q;
    endcase
  end

  assign base_next = base_d;

endmodule
`default_nettype wire

// File: rtl/traffic_light_fsm.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | traffic_light_fsm : timed Moore sequencer for main/side/walk lamps with  |
// | programmable intervals and a remaining-time output. Revision 1.0         |
// +--------------------------------------------------------------------------+
module traffic_light_fsm
  import traffic_pkg::*;
#(
  parameter int TW             = 4,
  parameter int T_BASE_DEFAULT = 6,
  parameter int T_EXT_DEFAULT  = 3,
  parameter int T_YEL_DEFAULT  = 2
) (
  input  logic          clk,
  input  logic          global_reset,
  input  logic          one_hz_enable,
  input  logic          traffic_sensor_sync,
  input  logic          walk_request_sync,
  input  logic          reprogram_sync,
  input  logic [1:0]    time_parameter_selector,
  input  logic [TW-1:0] time_value,
  output logic [2:0]    main_light,
  output logic [2:0]    side_light,
  output logic          walk_light,
  output logic [TW-1:0] time_remaining
);

  state_e        state_q, state_d, state_next;
  logic [TW-1:0] counter_q, counter_d;
  logic          walk_pending_q, walk_pending_d;
  logic [2:0]    main_light_q, main_light_d;
  logic [2:0]    side_light_q, side_light_d;
  logic          walk_light_q, walk_light_d;
  logic [TW-1:0] interval;
  logic [TW-1:0] base_next;

  timing_parameters #(
    .TW             (TW),
    .T_BASE_DEFAULT (T_BASE_DEFAULT),
    .T_EXT_DEFAULT  (T_EXT_DEFAULT),
    .T_YEL_DEFAULT  (T_YEL_DEFAULT)
  ) u_timing_parameters (
    .clk          (clk),
    .global_reset (global_reset),
    .reprogram    (reprogram_sync),
    .sel          (time_parameter_selector),
    .value        (time_value),
    .interval_sel (interval_of(state_next)),
    .interval     (interval),
    .base_next    (base_next)
  );

  // Successor taken at expiry; the sensor only matters on that edge
  always_comb begin
    case (state_q)
      ST_MG:     state_next = traffic_sensor_sync ? ST_MG_EXT : ST_MY;
      ST_MG_EXT: state_next = ST_MY;
      ST_MY:     state_next = walk_pending_q ? ST_WALK : ST_SG;
      ST_WALK:   state_next = ST_SG;
      ST_SG:     state_next = traffic_sensor_sync ? ST_SG_EXT : ST_SY;
      ST_SG_EXT: state_next = ST_SY;
      default:   state_next = ST_MG;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    counter_d      = counter_q;
    walk_pending_d = walk_pending_q;
    if (walk_request_sync && state_q != ST_WALK) begin
      walk_pending_d = 1'b1;
    end
    if (reprogram_sync) begin
      state_d   = ST_MG;
      counter_d = base_next;
    end else if (one_hz_enable) begin
      if (counter_q <= TW'(1)) begin
        state_d   = state_next;
        counter_d = interval;
      end else begin
        counter_d = counter_q - TW'(1);
      end
    end
    if (state_d == ST_WALK && state_q != ST_WALK) begin
      walk_pending_d = 1'b0;
    end
  end

  // Lamps are registered alongside the state so they change on the same edge
  always_comb begin
    main_light_d = LIGHT_RED;
    side_light_d = LIGHT_RED;
    walk_light_d = 1'b0;
    case (state_d)
      ST_MG, ST_MG_EXT: main_light_d = LIGHT_GRN;
      ST_MY:            main_light_d = LIGHT_YEL;
      ST_WALK:          walk_light_d = 1'b1;
      ST_SG, ST_SG_EXT: side_light_d = LIGHT_GRN;
      ST_SY:            side_light_d = LIGHT_YEL;
      default:          main_light_d = LIGHT_GRN;
    endcase
  end

  always_ff @(posedge clk or posedge global_reset) begin
    if (global_reset) begin
      state_q        <= ST_MG;
      counter_q      <= TW'(T_BASE_DEFAULT);
      walk_pending_q <= 1'b0;
      main_light_q   <= LIGHT_GRN;
      side_light_q   <= LIGHT_RED;
      walk_light_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      counter_q      <= counter_d;
      walk_pending_q <= walk_pending_d;
      main_light_q   <= main_light_d;
      side_light_q   <= side_light_d;
      walk_light_q   <= walk_light_d;
    end
  end

  assign main_light     = main_light_q;
  assign side_light     = side_light_q;
  assign walk_light     = walk_light_q;
  assign time_remaining = counter_q;

endmodule
`default_nettype wire

// File: tb/tb_traffic_light_fsm.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_traffic_light_fsm : directed self-checking bench for                  |
// | traffic_light_fsm.                                  Revision 1.0         |
// +--------------------------------------------------------------------------+
module tb_traffic_light_fsm;

  localparam int MG = 0, MGX = 1, MY = 2, WK = 3, SG = 4, SGX = 5, SY = 6;

  logic       clk = 1'b0;
  logic       global_reset = 1'b1;
  logic       one_hz_enable = 1'b0;
  logic       traffic_sensor_sync = 1'b0;
  logic       walk_request_sync = 1'b0;
  logic       reprogram_sync = 1'b0;
  logic [1:0] time_parameter_selector = 2'b00;
  logic [3:0] time_value = 4'd0;
  logic [2:0] main_light, side_light;
  logic       walk_light;
  logic [3:0] time_remaining;

  int n_checks = 0;
  int n_fail   = 0;

  traffic_light_fsm dut (
    .clk                     (clk),
    .global_reset            (global_reset),
    .one_hz_enable           (one_hz_enable),
    .traffic_sensor_sync     (traffic_sensor_sync),
    .walk_request_sync       (walk_request_sync),
    .reprogram_sync          (reprogram_sync),
    .time_parameter_selector (time_parameter_selector),
    .time_value              (time_value),
    .main_light              (main_light),
    .side_light              (side_light),
    .walk_light              (walk_light),
    .time_remaining          (time_remaining)
  );

  always #5 clk = ~clk;

  // Expected {main, side, walk} for each state, straight from the state table
  function automatic logic [6:0] exp_lights(input int st);
    case (st)
      MG, MGX: exp_lights = 7'b001_100_0;
      MY:      exp_lights = 7'b010_100_0;
      WK:      exp_lights = 7'b100_100_1;
      SG, SGX: exp_lights = 7'b100_001_0;
      SY:      exp_lights = 7'b100_010_0;
      default: exp_lights = 7'b000_000_0;
    endcase
  endfunction

  function automatic logic [10:0] obs();
    obs = {main_light, side_light, walk_light, time_remaining};
  endfunction

  // One tick every 4 clk; leaves the bench 1 time unit after an edge
  task automatic tick();
    one_hz_enable = 1'b1;
    @(posedge clk); #1;
    one_hz_enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [10:0] e;
    repeat (2) @(posedge clk);
    #1;
    global_reset = 1'b0;
    e = {7'b001_100_0, 4'd6};
    n_checks++;
    if (obs() !== e) begin
      n_fail++;
      $display("FAIL reset_state: got %b required %b", obs(), e);
    end
  endtask

  task automatic test_normal_cycle();
    int st[4]  = '{MG, MY, SG, SY};
    int dur[4] = '{6, 2, 6, 2};
    logic [10:0] e;
    for (int p = 0; p < 4; p++) begin
      for (int r = dur[p]; r >= 1; r--) begin
        e = {exp_lights(st[p]), 4'(r)};
        n_checks++;
        if (obs() !== e) begin
          n_fail++;
          $display("FAIL normal_cycle phase %0d rem %0d: got %b required %b", p, r, obs(), e);
        end
        tick();
      end
    end
    e = {exp_lights(MG), 4'd6};
    n_checks++;
    if (obs() !== e) begin
      n_fail++;
      $display("FAIL normal_cycle wrap: got %b required %b", obs(), e);
    end
  endtask

  task automatic test_sensor_extension();
    int st[6]  = '{MG, MGX, MY, SG, SGX, SY};
    int dur[6] = '{6, 3, 2, 6, 3, 2};
    logic [10:0] e;
    traffic_sensor_sync = 1'b1;
    for (int p = 0; p < 6; p++) begin
      for (int r = dur[p]; r >= 1; r--) begin
        e = {exp_lights(st[p]), 4'(r)};
        n_checks++;
        if (obs() !== e) begin
          n_fail++;
          $display("FAIL sensor_ext phase %0d rem %0d: got %b required %b", p, r, obs(), e);
        end
        tick();
      end
    end
    traffic_sensor_sync = 1'b0;
    e = {exp_lights(MG), 4'd6};
    n_checks++;
    if (obs() !== e) begin
      n_fail++;
      $display("FAIL sensor_ext wrap: got %b required %b", obs(), e);
    end
  endtask

  task automatic test_walk_request();
    int st[9]  = '{MG, MY, WK, SG, SY, MG, MY, SG, SY};
    int dur[9] = '{6, 2, 3, 6, 2, 6, 2, 6, 2};
    logic [10:0] e;
    for (int p = 0; p < 9; p++) begin
      for (int r = dur[p]; r >= 1; r--) begin
        e = {exp_lights(st[p]), 4'(r)};
        n_checks++;
        if (obs() !== e) begin
          n_fail++;
          $display("FAIL walk phase %0d rem %0d: got %b required %b", p, r, obs(), e);
        end
        // first pulse during MG is served; second pulse during WALK is dropped
        if ((p == 0 && r == 4) || (p == 2 && r == 2)) begin
          walk_request_sync = 1'b1;
          @(posedge clk); #1;
          walk_request_sync = 1'b0;
        end
        tick();
      end
    end
  endtask

  task automatic test_reprogram_base();
    logic [10:0] e;
    repeat (9) tick();
    e = {exp_lights(SG), 4'd5};
    n_checks++;
    if (obs() !== e) begin
      n_fail++;
      $display("FAIL reprog_pre: got %b required %b", obs(), e);
    end
    reprogram_sync = 1'b1;
    time_parameter_selector = 2'b00;
    time_value = 4'd9;
    @(posedge clk); #1;
    reprogram_sync = 1'b0;
    for (int r = 9; r >= 1; r--) begin
      e = {exp_lights(MG), 4'(r)};
      n_checks++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL reprog_base9 rem %0d: got %b required %b", r, obs(), e);
      end
      tick();
    end
    e = {exp_lights(MY), 4'd2};
    n_checks++;
    if (obs() !== e) begin
      n_fail++;
      $display("FAIL reprog_base9_end: got %b required %b", obs(), e);
    end
    reprogram_sync = 1'b1;
    time_parameter_selector = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    reprogram_sync = 1'b0;
    for (int r = 6; r >= 1; r--) begin
      e = {exp_lights(MG), 4'(r)};
      n_checks++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL reprog_defaults rem %0d: got %b required %b", r, obs(), e);
      end
      tick();
    end
    e = {exp_lights(MY), 4'd2};
    n_checks++;
    if (obs() !== e) begin
      n_fail++;
      $display("FAIL reprog_defaults_end: got %b required %b", obs(), e);
    end
  endtask

  task automatic test_yellow_zero_and_tick();
    int st[3]  = '{MG, MY, SG};
    int dur[3] = '{6, 2, 6};
    logic [10:0] e;
    reprogram_sync = 1'b1;
    time_parameter_selector = 2'b10;
    time_value = 4'd5;
    @(posedge clk); #1;
    time_value = 4'd0;
    one_hz_enable = 1'b1;
    @(posedge clk); #1;
    reprogram_sync = 1'b0;
    one_hz_enable = 1'b0;
    for (int p = 0; p < 3; p++) begin
      for (int r = dur[p]; r >= 1; r--) begin
        e = {exp_lights(st[p]), 4'(r)};
        n_checks++;
        if (obs() !== e) begin
          n_fail++;
          $display("FAIL yel_zero phase %0d rem %0d: got %b required %b", p, r, obs(), e);
        end
        tick();
      end
    end
    e = {exp_lights(SY), 4'd2};
    n_checks++;
    if (obs() !== e) begin
      n_fail++;
      $display("FAIL yel_zero_sy: got %b required %b", obs(), e);
    end
  endtask

  task automatic test_async_reset();
    int st[2]  = '{MG, MY};
    int dur[2] = '{6, 2};
    logic [10:0] e;
    walk_request_sync = 1'b1;
    @(posedge clk); #1;
    walk_request_sync = 1'b0;
    @(posedge clk); #3;
    global_reset = 1'b1;
    #1;
    e = {7'b001_100_0, 4'd6};
    n_checks++;
    if (obs() !== e) begin
      n_fail++;
      $display("FAIL async_reset: got %b required %b", obs(), e);
    end
    @(posedge clk); #1;
    global_reset = 1'b0;
    for (int p = 0; p < 2; p++) begin
      for (int r = dur[p]; r >= 1; r--) begin
        e = {exp_lights(st[p]), 4'(r)};
        n_checks++;
        if (obs() !== e) begin
          n_fail++;
          $display("FAIL post_reset phase %0d rem %0d: got %b required %b", p, r, obs(), e);
        end
        tick();
      end
    end
    e = {exp_lights(SG), 4'd6};
    n_checks++;
    if (obs() !== e) begin
      n_fail++;
      $display("FAIL post_reset_no_walk: got %b required %b", obs(), e);
    end
  endtask

  initial begin
    test_reset();
    test_normal_cycle();
    test_sensor_extension();
    test_walk_request();
    test_reprogram_base();
    test_yellow_zero_and_tick();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
